// File: rtl/countdown_timer.sv
// Down-counting HH:MM:SS timer with a clk prescaler, pause/resume and expiry flagging.
// Fields are binary and share the stopwatch's 8-bit sout/mout/hout encoding.
module countdown_timer #(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] h_in,
   input  logic [7:0] m_in,
   input  logic [7:0] s_in,
   input  logic       start,
   input  logic       pause,
   output logic [7:0] sout,
   output logic [7:0] mout,
   output logic [7:0] hout,
   output logic       running,
   output logic       expired,
   output logic       done
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSED,
      DONE
   } state_e;

   state_e        state_q;
   logic [PW-1:0] presc_q;
   logic [7:0]    s_q, m_q, h_q;
   logic          running_q, expired_q, done_q;

   logic [7:0]    s_d, m_d, h_d;
   logic          step_zero_d, count_zero_d, tick_d;

   // One borrow-chain step of the current count; only committed on a prescaler wrap.
   always_comb begin
      s_d = s_q;
      m_d = m_q;
      h_d = h_q;
      if (s_q != 8'd0) begin
         s_d = s_q - 8'd1;
      end else if (m_q != 8'd0) begin
         s_d = 8'd59;
         m_d = m_q - 8'd1;
      end else if (h_q != 8'd0) begin
         s_d = 8'd59;
         m_d = 8'd59;
         h_d = h_q - 8'd1;
      end
      step_zero_d  = (s_d == 8'd0) && (m_d == 8'd0) && (h_d == 8'd0);
      count_zero_d = (s_q == 8'd0) && (m_q == 8'd0) && (h_q == 8'd0);
      tick_d       = (presc_q == PW'(TICK_DIV - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         s_q       <= '0;
         m_q       <= '0;
         h_q       <= '0;
         running_q <= 1'b0;
         expired_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (load) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            s_q       <= (s_in > 8'd59) ? 8'd59 : s_in;
            m_q       <= (m_in > 8'd59) ? 8'd59 : m_in;
            h_q       <= (h_in > 8'd23) ? 8'd23 : h_in;
            running_q <= 1'b0;
            expired_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE, PAUSED: begin
                  if (start) begin
                     if (count_zero_d) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        expired_q <= 1'b1;
                        running_q <= 1'b0;
                     end else begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                        if (state_q == IDLE) presc_q <= '0;
                     end
                  end
               end
               RUN: begin
                  // The prescaler still advances on the pause edge, so resume lands
                  // TICK_DIV-1-p cycles later; reaching zero outranks a concurrent pause.
                  if (tick_d) begin
                     presc_q <= '0;
                     s_q     <= s_d;
                     m_q     <= m_d;
                     h_q     <= h_d;
                  end else begin
                     presc_q <= presc_q + 1'b1;
                  end
                  if (tick_d && step_zero_d) begin
                     state_q   <= DONE;
                     done_q    <= 1'b1;
                     expired_q <= 1'b1;
                     running_q <= 1'b0;
                  end else if (pause) begin
                     state_q   <= PAUSED;
                     running_q <= 1'b0;
                  end
               end
               DONE: begin
               end
               default: begin
                  state_q   <= IDLE;
                  running_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign sout    = s_q;
   assign mout    = m_q;
   assign hout    = h_q;
   assign running = running_q;
   assign expired = expired_q;
   assign done    = done_q;

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Down-counting hours/minutes/seconds timer, the complement of the team's up-counting stopwatch. It loads a preset time, decrements it once per prescaled tick while running, and flags expiry at 00:00:00. It sits beside the stopwatch in the timekeeping path. Its binary sout/mout/hout outputs use the same 8-bit encoding, so the same display logic can consume either block.

## Interface
- TICK_DIV, default 50_000_000: clk cycles per count step (≥1); 1 Hz at 50 MHz.
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  synchronous, active-high reset.
- load  input  1  load h_in/m_in/s_in into the counter.
- h_in  input  8  preset hours, binary.
- m_in  input  8  preset minutes, binary.
- s_in  input  8  preset seconds, binary.
- start  input  1  begin/resume counting.
- pause  input  1  suspend counting.
- sout  output  8  current seconds, 0..59.
- mout  output  8  current minutes, 0..59.
- hout  output  8  current hours, 0..23.
- running  output  1  high in RUN state.
- expired  output  1  high in DONE state.
- done  output  1  one-cycle pulse on reaching 00:00:00 by counting.

## Operation
- States: IDLE, RUN, PAUSED, DONE. All outputs are registered.
- Reset (rst=1 at an edge): state=IDLE, sout=mout=hout=0, prescaler=0, running=expired=done=0. Reset overrides every other input, including mid-RUN.
- Input priority at each edge: rst > load > start > pause.
- load (any state): go to IDLE and clear the prescaler.
  - Saturate each field before storing: s_in>59→59, m_in>59→59, h_in>23→23.
  - The loaded value appears on the outputs the edge after load is sampled.
- start:
  - From IDLE or PAUSED with a nonzero count → RUN. From IDLE only, also clear the prescaler.
  - From IDLE or PAUSED with count 00:00:00 → DONE, done=1 for one cycle.
  - Ignored in RUN and DONE.
- pause: RUN → PAUSED. The prescaler and count hold. Ignored in all other states.
- start and pause together: RUN applies pause; PAUSED applies start.
- Prescaler (RUN only): counts 0..TICK_DIV-1. At the edge where it equals TICK_DIV-1, it wraps to 0 and the count steps once.
- Count step (borrow chain):
  - s>0: s−1.
  - s=0, m>0: s=59, m−1.
  - s=0, m=0, h>0: s=59, m=59, h−1.
- If a step produces 00:00:00, the same edge sets state=DONE and done=1. done drops to 0 on the next edge.
- DONE: count holds at 0 and expired=1. Only load or rst leaves DONE.
- Width rule: all fields are 8-bit unsigned. Values never exceed 59/59/23 and never wrap below 0.

## Timing
- Start accepted at edge E0 from IDLE: the first step occurs at edge E0+TICK_DIV, then every TICK_DIV cycles.
- Pause at edge P holds the prescaler value p. After resume at edge R, the next step occurs at R+(TICK_DIV−1−p).
- TICK_DIV=1: one step per RUN cycle.
- running and expired change on the same edge as the state change.
- Total run length from a load of H:M:S is (3600H+60M+S)·TICK_DIV cycles.

## Test plan
All scenarios use TICK_DIV=4.
- Reset:
  - Assert rst for 2 cycles with random inputs → sout=mout=hout=0, running=expired=done=0, state IDLE.
  - Reissue rst mid-RUN → same result at the next edge.
- Seconds and minutes borrow:
  - load 0:1:0, start at E0 → 00:00:59 at E0+4, 00:00:58 at E0+8.
  - load 1:0:0, start → 00:59:59 at E0+4.
- Expiry:
  - load 0:0:2, start at E0 → 00:00:01 at E0+4, 00:00:00 at E0+8.
  - done=1 only during cycle E0+8..E0+9. expired stays 1 and running=0 from E0+8.
  - Further start is ignored and the count holds at 0.
- Pause/resume:
  - load 0:0:10, start at E0, pause at E0+6 (prescaler=1) → count holds at 00:00:09 for 20 cycles.
  - start at R → 00:00:08 at R+2.
- Clamp and zero start:
  - load 99/99/99 → 23:59:59.
  - load 0/0/0 then start → DONE with a one-cycle done pulse on the next edge.
- Priority:
  - load and start together → load wins, state IDLE.
  - start and pause together in RUN → PAUSED.
  - start and pause together in PAUSED → RUN.
